// File: rtl/cpu_debug_controller.sv
// Host debug command engine: decodes opcode words, drives CPU reset/run/halt/step, one response per command.
// Optional PC breakpoint halting is built when CPU_DBG_BREAKPOINT_EN is defined.
module cpu_debug_controller #(
  parameter int XLEN         = 32,
  parameter int RESET_CYCLES = 4,
  parameter int STEP_W       = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] cmd_data_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [XLEN-1:0] pc_i,
  output logic            cpu_reset_o,
  output logic            cpu_run_o,
  output logic [XLEN-1:0] resp_data_o,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic            halted_o,
  output logic            bp_hit_o,
  output logic [1:0]      state_o,
  output logic [1:0]      run_mode_o
);
  // Handshakes: a command word moves on cmd_valid_i & cmd_ready_o; a response moves on
  // resp_valid_o & resp_ready_i, and resp_data_o is held stable while resp_ready_i is low.
  localparam logic [1:0] S_IDLE = 2'd0, S_ARG = 2'd1, S_RSTHOLD = 2'd2, S_RESP = 2'd3;
  localparam logic [1:0] M_HALT = 2'd0, M_FREE = 2'd1, M_STEP = 2'd2;
  localparam logic [7:0] OP_RESET = 8'h01, OP_READ_PC = 8'h02, OP_RUN = 8'h03;
  localparam logic [7:0] OP_HALT = 8'h04, OP_STEP = 8'h05;
`ifdef CPU_DBG_BREAKPOINT_EN
  localparam logic [7:0] OP_SET_BP = 8'h06, OP_CLR_BP = 8'h07;
`endif
  localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RESET_CYCLES - 1);
  localparam logic [XLEN-1:0] RESP_ACK = {{(XLEN-8){1'b0}}, 8'hA5};
  localparam logic [XLEN-1:0] RESP_NAK = {{(XLEN-8){1'b0}}, 8'hEE};

  logic [1:0]        state_q, state_d;
  logic              arg_step_q, arg_step_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [XLEN-1:0]   resp_q, resp_d;
  logic [1:0]        mode_q, mode_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic              bp_hit_q, bp_hit_d;
  logic              bp_match;
  logic              unused_cmd_bits;
  logic [7:0]        opcode;
  logic [STEP_W-1:0] arg_cnt;
`ifdef CPU_DBG_BREAKPOINT_EN
  logic [XLEN-1:0]   bp_addr_q, bp_addr_d;
  logic              bp_valid_q, bp_valid_d;
  logic              skip_q, skip_d;

  // skip masks the match for one cycle after a resume so the core can leave the breakpoint PC.
  assign bp_match = bp_valid_q && (pc_i == bp_addr_q) && (mode_q != M_HALT) && !skip_q;
`else
  assign bp_match = 1'b0;
`endif

  assign opcode          = cmd_data_i[7:0];
  assign arg_cnt         = cmd_data_i[STEP_W-1:0];
  assign unused_cmd_bits = ^cmd_data_i;

  assign cmd_ready_o  = (state_q == S_IDLE) || (state_q == S_ARG);
  assign cpu_reset_o  = (state_q == S_RSTHOLD);
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_data_o  = resp_q;
  assign halted_o     = (mode_q == M_HALT);
  assign bp_hit_o     = bp_hit_q;
  assign state_o      = state_q;
  assign run_mode_o   = mode_q;
  assign cpu_run_o    = ((mode_q == M_FREE) || ((mode_q == M_STEP) && (step_cnt_q != '0)))
                        && !cpu_reset_o && !bp_match;

  always_comb begin
    state_d    = state_q;
    arg_step_d = arg_step_q;
    rst_cnt_d  = rst_cnt_q;
    resp_d     = resp_q;
    mode_d     = mode_q;
    step_cnt_d = step_cnt_q;
    bp_hit_d   = bp_hit_q;
`ifdef CPU_DBG_BREAKPOINT_EN
    bp_addr_d  = bp_addr_q;
    bp_valid_d = bp_valid_q;
    skip_d     = 1'b0;
`endif
    if (cpu_run_o && (mode_q == M_STEP)) begin
      step_cnt_d = step_cnt_q - STEP_W'(1);
      if (step_cnt_q == STEP_W'(1)) mode_d = M_HALT;
    end
`ifdef CPU_DBG_BREAKPOINT_EN
    if (bp_match) begin
      mode_d     = M_HALT;
      step_cnt_d = '0;
      bp_hit_d   = 1'b1;
    end
`endif
    // Accepted commands are applied after execution progress so they take priority.
    case (state_q)
      S_IDLE: if (cmd_valid_i) begin
        state_d = S_RESP;
        resp_d  = RESP_ACK;
        case (opcode)
          OP_RESET: begin
            state_d    = S_RSTHOLD;
            rst_cnt_d  = RST_LOAD;
            mode_d     = M_HALT;
            step_cnt_d = '0;
            bp_hit_d   = 1'b0;
          end
          OP_READ_PC: resp_d = pc_i;
          OP_RUN: begin
            mode_d   = M_FREE;
            bp_hit_d = 1'b0;
`ifdef CPU_DBG_BREAKPOINT_EN
            skip_d   = 1'b1;
`endif
          end
          OP_HALT: begin
            mode_d     = M_HALT;
            step_cnt_d = '0;
          end
          OP_STEP: begin
            if (mode_q == M_HALT) begin
              state_d    = S_ARG;
              arg_step_d = 1'b1;
            end else begin
              resp_d = RESP_NAK;
            end
          end
`ifdef CPU_DBG_BREAKPOINT_EN
          OP_SET_BP: begin
            state_d    = S_ARG;
            arg_step_d = 1'b0;
          end
          OP_CLR_BP: bp_valid_d = 1'b0;
`endif
          default: resp_d = RESP_NAK;
        endcase
      end
      S_ARG: if (cmd_valid_i) begin
        state_d = S_RESP;
        resp_d  = RESP_ACK;
        if (arg_step_q) begin
          bp_hit_d = 1'b0;
          if (arg_cnt != '0) begin
            mode_d     = M_STEP;
            step_cnt_d = arg_cnt;
`ifdef CPU_DBG_BREAKPOINT_EN
            skip_d     = 1'b1;
`endif
          end
        end
`ifdef CPU_DBG_BREAKPOINT_EN
        else begin
          bp_addr_d  = cmd_data_i;
          bp_valid_d = 1'b1;
        end
`endif
      end
      S_RSTHOLD: begin
        if (rst_cnt_q == '0) state_d = S_RESP;
        else                 rst_cnt_d = rst_cnt_q - RST_W'(1);
      end
      default: if (resp_ready_i) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      arg_step_q <= 1'b1;
      rst_cnt_q  <= '0;
      resp_q     <= '0;
      mode_q     <= M_HALT;
      step_cnt_q <= '0;
      bp_hit_q   <= 1'b0;
`ifdef CPU_DBG_BREAKPOINT_EN
      bp_addr_q  <= '0;
      bp_valid_q <= 1'b0;
      skip_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      arg_step_q <= arg_step_d;
      rst_cnt_q  <= rst_cnt_d;
      resp_q     <= resp_d;
      mode_q     <= mode_d;
      step_cnt_q <= step_cnt_d;
      bp_hit_q   <= bp_hit_d;
`ifdef CPU_DBG_BREAKPOINT_EN
      bp_addr_q  <= bp_addr_d;
      bp_valid_q <= bp_valid_d;
      skip_q     <= skip_d;
`endif
    end
  end
endmodule

// File: tb/tb_cpu_debug_controller.sv
// Bench for cpu_debug_controller: directed host commands, a command-level reference model with a
// response queue checked every cycle, and a toy CPU whose pc advances by 4 per cpu_run cycle.
module tb_cpu_debug_controller;
  localparam int RESET_CYCLES = 4;
  localparam logic [31:0] ACK = 32'h0000_00A5;
  localparam logic [31:0] NAK = 32'h0000_00EE;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cmd_data = '0;
  logic        cmd_valid = 1'b0;
  logic        resp_ready = 1'b1;
  logic [31:0] pc = '0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_load_val = '0;

  logic        cmd_ready_o, cpu_reset_o, cpu_run_o, resp_valid_o, halted_o, bp_hit_o;
  logic [31:0] resp_data_o;
  logic [1:0]  state_o, run_mode_o;

  cpu_debug_controller #(.XLEN(32), .RESET_CYCLES(RESET_CYCLES), .STEP_W(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_data_i(cmd_data), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
    .pc_i(pc), .cpu_reset_o(cpu_reset_o), .cpu_run_o(cpu_run_o),
    .resp_data_o(resp_data_o), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready),
    .halted_o(halted_o), .bp_hit_o(bp_hit_o), .state_o(state_o), .run_mode_o(run_mode_o)
  );

  // ---------------- clock / reset / cycle count / toy CPU
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pc_load)          pc <= pc_load_val;
    else if (cpu_reset_o) pc <= '0;
    else if (cpu_run_o)   pc <= pc + 32'd4;
  end

  // ---------------- counters and checking helpers
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting on the DUT (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model: command-level view of the controller
  logic [31:0] exp_q[$];
  int          m_rst_left = 0;
  int          m_wait_arg = 0;
  int          m_mode = 0;
  int          m_steps = 0;
  logic [31:0] m_bp_addr = '0;
  bit          m_bp_valid = 1'b0;
  bit          m_skip = 1'b0;
  bit          m_bp_hit = 1'b0;
  bit          m_live = 1'b0;

  function automatic bit m_bpm();
`ifdef CPU_DBG_BREAKPOINT_EN
    return m_bp_valid && (pc == m_bp_addr) && (m_mode != 0) && !m_skip;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_ready();
    return (m_rst_left == 0) && (exp_q.size() == 0);
  endfunction

  function automatic bit m_resp_valid();
    return (m_rst_left == 0) && (exp_q.size() > 0);
  endfunction

  function automatic bit m_run();
    return ((m_mode == 1) || ((m_mode == 2) && (m_steps > 0))) && (m_rst_left == 0) && !m_bpm();
  endfunction

  always @(posedge clk) begin
    bit rdy, run, bpm, rv;
    int mode_pre, cnt;
    rdy = m_ready();
    run = m_run();
    bpm = m_bpm();
    rv = m_resp_valid();
    mode_pre = m_mode;
    if (reset) begin
      exp_q.delete();
      m_rst_left = 0; m_wait_arg = 0; m_mode = 0; m_steps = 0;
      m_bp_addr = '0; m_bp_valid = 1'b0; m_skip = 1'b0; m_bp_hit = 1'b0;
      m_live = 1'b1;
    end else begin
      if (run && m_mode == 2) begin
        m_steps = m_steps - 1;
        if (m_steps == 0) m_mode = 0;
      end
      if (bpm) begin
        m_mode = 0; m_steps = 0; m_bp_hit = 1'b1;
      end
      m_skip = 1'b0;
      if (rv && resp_ready) void'(exp_q.pop_front());
      if (m_rst_left > 0) begin
        m_rst_left = m_rst_left - 1;
        if (m_rst_left == 0) exp_q.push_back(ACK);
      end
      if (cmd_valid && rdy) begin
        if (m_wait_arg == 5) begin
          cnt = int'(cmd_data[15:0]);
          m_bp_hit = 1'b0;
          if (cnt != 0) begin
            m_mode = 2; m_steps = cnt; m_skip = 1'b1;
          end
          exp_q.push_back(ACK);
          m_wait_arg = 0;
        end else if (m_wait_arg == 6) begin
          m_bp_addr = cmd_data; m_bp_valid = 1'b1;
          exp_q.push_back(ACK);
          m_wait_arg = 0;
        end else begin
          case (cmd_data[7:0])
            8'h01: begin m_mode = 0; m_steps = 0; m_bp_hit = 1'b0; m_rst_left = RESET_CYCLES; end
            8'h02: exp_q.push_back(pc);
            8'h03: begin m_mode = 1; m_bp_hit = 1'b0; m_skip = 1'b1; exp_q.push_back(ACK); end
            8'h04: begin m_mode = 0; m_steps = 0; exp_q.push_back(ACK); end
            8'h05: begin
              if (mode_pre == 0) m_wait_arg = 5;
              else               exp_q.push_back(NAK);
            end
`ifdef CPU_DBG_BREAKPOINT_EN
            8'h06: m_wait_arg = 6;
            8'h07: begin m_bp_valid = 1'b0; exp_q.push_back(ACK); end
`endif
            default: exp_q.push_back(NAK);
          endcase
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model
  always @(negedge clk) begin
    if (m_live) begin
      check("cmd_ready", cmd_ready_o, m_ready());
      check("cpu_reset", cpu_reset_o, m_rst_left > 0);
      check("cpu_run", cpu_run_o, m_run());
      check("resp_valid", resp_valid_o, m_resp_valid());
      check("halted", halted_o, m_mode == 0);
      check("bp_hit", bp_hit_o, m_bp_hit);
      if (m_resp_valid()) check("resp_data", resp_data_o, exp_q[0]);
    end
  end

  // ---------------- activity monitors for the directed checks
  int run_cnt = 0, run_first = 0, run_last = 0, rst_hi = 0;
  always @(negedge clk) begin
    if (cpu_run_o) begin
      if (run_cnt == 0) run_first = cyc;
      run_last = cyc;
      run_cnt++;
    end
    if (cpu_reset_o) rst_hi++;
  end

  // ---------------- driver tasks (called at a negedge, return at a negedge)
  int acc_cyc = 0;

  task automatic send_word(input logic [31:0] w);
    int t;
    t = 0;
    cmd_data = w;
    cmd_valid = 1'b1;
    while (!cmd_ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready_o) fail_now("cmd_accept");
    @(posedge clk);
    acc_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(output logic [31:0] d, output int lat);
    int t;
    t = 0;
    while (!resp_valid_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!resp_valid_o) begin
      fail_now("resp_wait");
      d = 'x;
      lat = -1;
    end else begin
      d = resp_data_o;
      lat = cyc - acc_cyc;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_pc(input logic [31:0] v);
    pc_load_val = v;
    pc_load = 1'b1;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  // ---------------- directed sequence
  initial begin
    logic [31:0] r;
    int lat, acc;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_cpu_reset", cpu_reset_o, 0);
    check("rst_cpu_run", cpu_run_o, 0);
    check("rst_resp_valid", resp_valid_o, 0);
    check("rst_resp_data", resp_data_o, 0);
    check("rst_halted", halted_o, 1);
    check("rst_bp_hit", bp_hit_o, 0);
    reset = 1'b0;
    @(negedge clk);

    // RESET command: 4-cycle CPU reset pulse then ACK
    rst_hi = 0;
    send_word(32'h0000_0001);
    wait_resp(r, lat);
    check("reset_resp", r, ACK);
    check("reset_lat", lat, 5);
    check("reset_hold", rst_hi, 4);
    check("reset_halted", halted_o, 1);

    // READ_PC with the transmitter stalled for 5 cycles
    load_pc(32'h0000_0040);
    resp_ready = 1'b0;
    send_word(32'h0000_0002);
    for (int i = 0; i < 5; i++) begin
      check("rdpc_valid", resp_valid_o, 1);
      check("rdpc_data", resp_data_o, 32'h0000_0040);
      check("rdpc_ready_low", cmd_ready_o, 0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    wait_resp(r, lat);
    check("rdpc_final", r, 32'h0000_0040);

    // STEP 3 then STEP 0
    run_cnt = 0;
    send_word(32'h0000_0005);
    send_word(32'h0000_0003);
    acc = acc_cyc;
    wait_resp(r, lat);
    check("step3_ack", r, ACK);
    check("step3_lat", lat, 1);
    repeat (5) @(negedge clk);
    check("step3_runs", run_cnt, 3);
    check("step3_first", run_first - acc, 1);
    check("step3_last", run_last - acc, 3);
    check("step3_halted", halted_o, 1);
    check("step3_pc", pc, 32'h0000_004C);
    run_cnt = 0;
    send_word(32'h0000_0005);
    send_word(32'h0000_0000);
    wait_resp(r, lat);
    repeat (3) @(negedge clk);
    check("step0_ack", r, ACK);
    check("step0_runs", run_cnt, 0);
    check("step0_halted", halted_o, 1);

    // RUN, HALT accepted 20 cycles later
    run_cnt = 0;
    send_word(32'h0000_0003);
    acc = acc_cyc;
    wait_resp(r, lat);
    check("run_ack", r, ACK);
    while (cyc < acc + 20) @(negedge clk);
    send_word(32'h0000_0004);
    check("halt_accept_at", acc_cyc - acc, 20);
    wait_resp(r, lat);
    check("halt_ack", r, ACK);
    repeat (2) @(negedge clk);
    check("run_cycles", run_cnt, 20);
    check("run_first", run_first - acc, 1);
    check("run_halted", halted_o, 1);

    // STEP while running is refused without an argument word; HALT with junk upper bits
    send_word(32'h0000_0003);
    wait_resp(r, lat);
    send_word(32'h0000_0005);
    wait_resp(r, lat);
    check("step_busy_nak", r, NAK);
    send_word(32'hFFFF_FF04);
    wait_resp(r, lat);
    check("halt_upper_ack", r, ACK);
    check("halt_upper_halted", halted_o, 1);

    // unknown opcodes
    send_word(32'h0000_0099);
    wait_resp(r, lat);
    check("unknown_nak", r, NAK);
    send_word(32'h0000_0000);
    wait_resp(r, lat);
    check("zero_op_nak", r, NAK);

    // block reset while waiting for the STEP argument
    send_word(32'h0000_0005);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_arg_ready", cmd_ready_o, 1);
    repeat (3) begin
      @(negedge clk);
      check("abort_arg_no_resp", resp_valid_o, 0);
    end
    send_word(32'h0000_0099);
    wait_resp(r, lat);
    check("abort_arg_next_cmd", r, NAK);

    // block reset during the CPU reset pulse
    send_word(32'h0000_0001);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_rst_drop", cpu_reset_o, 0);
    repeat (RESET_CYCLES + 2) begin
      @(negedge clk);
      check("abort_rst_no_resp", resp_valid_o, 0);
    end

`ifdef CPU_DBG_BREAKPOINT_EN
    // breakpoint at 0x10: run from 0 stops there, resume steps past it
    send_word(32'h0000_0006);
    send_word(32'h0000_0010);
    wait_resp(r, lat);
    check("setbp_ack", r, ACK);
    load_pc(32'h0000_0000);
    send_word(32'h0000_0003);
    wait_resp(r, lat);
    repeat (10) @(negedge clk);
    check("bp_stop_pc", pc, 32'h0000_0010);
    check("bp_stop_halted", halted_o, 1);
    check("bp_stop_hit", bp_hit_o, 1);
    check("bp_stop_run", cpu_run_o, 0);
    send_word(32'h0000_0003);
    wait_resp(r, lat);
    check("bp_resume_ack", r, ACK);
    repeat (3) @(negedge clk);
    check("bp_resume_past", pc > 32'h0000_0010, 1);
    check("bp_resume_hit", bp_hit_o, 0);
    send_word(32'h0000_0004);
    wait_resp(r, lat);
    send_word(32'h0000_0007);
    wait_resp(r, lat);
    check("clrbp_ack", r, ACK);
`else
    // breakpoint opcodes refused, and the word after them is a fresh command
    load_pc(32'h0000_1234);
    send_word(32'h0000_0006);
    wait_resp(r, lat);
    check("setbp_nak", r, NAK);
    send_word(32'h0000_0002);
    wait_resp(r, lat);
    check("setbp_no_arg", r, 32'h0000_1234);
    send_word(32'h0000_0007);
    wait_resp(r, lat);
    check("clrbp_nak", r, NAK);
    check("bp_hit_tied", bp_hit_o, 0);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
